mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_periph_seg7_decoder.sv | 11 +
 rtl/mmio_periph.sv | 123 ++++++++++++
 tb/tb_mmio_periph.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO peripheral: address map, TCON bit positions, 7-seg codes.
// MMIO_SCAN_EN widens DIGI to four hex nibbles for the scanned display.
package mmio_pkg;

  localparam logic [31:0] BASE_ADDR   = 32'h4000_0000;

  localparam logic [31:0] OFF_TH      = 32'h00;
  localparam logic [31:0] OFF_TL      = 32'h04;
  localparam logic [31:0] OFF_TCON    = 32'h08;
  localparam logic [31:0] OFF_LED     = 32'h0C;
  localparam logic [31:0] OFF_DIGI    = 32'h10;
  localparam logic [31:0] OFF_SYSTICK = 32'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;

`ifdef MMIO_SCAN_EN
  localparam int DIGI_W = 16;
`else
  localparam int DIGI_W = 12;
`endif

  // {dp,g,f,e,d,c,b,a}, dp always off
  localparam logic [7:0] SEG7_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/mmio_periph_seg7_decoder.sv
// Hex nibble to 7-segment code lookup, used only by the scanned display build.
module seg7_decoder
  import mmio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped timer / LED / 7-seg / systick block on the MEM-stage bus.
// Define MMIO_SCAN_EN to scan a 4-digit hex display instead of driving DIGI raw.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq
);

  logic [31:0]       th, tl, systick;
  logic [2:0]        tcon;
  logic [7:0]        led;
  logic [DIGI_W-1:0] digi_reg;
  logic [2:0]        sel;
  logic              wr, wr_tl, wr_tcon, tl_max, wrap;
  logic [11:0]       digi_raw;
  logic              unused_byte_lanes;

  assign sel               = Address[4:2];
  assign unused_byte_lanes = ^Address[1:0];
  assign hit     = (Address[31:5] == BASE_ADDR[31:5]) && (sel <= OFF_SYSTICK[4:2]);
  assign wr      = MemWrite && hit;
  assign wr_tl   = wr && (sel == OFF_TL[4:2]);
  assign wr_tcon = wr && (sel == OFF_TCON[4:2]);
  assign tl_max  = &tl;
  // A bus write to TL pre-empts the reload, so no interrupt is raised for it.
  assign wrap    = tcon[TCON_EN] && tl_max && !wr_tl;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th       <= '0;
      led      <= '0;
      digi_reg <= '0;
      systick  <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr && sel == OFF_TH[4:2])   th       <= Write_data;
      if (wr && sel == OFF_LED[4:2])  led      <= Write_data[7:0];
      if (wr && sel == OFF_DIGI[4:2]) digi_reg <= Write_data[DIGI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              tl <= '0;
    else if (wr_tl)          tl <= Write_data;
    else if (tcon[TCON_EN])  tl <= tl_max ? th : tl + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        tcon <= '0;
    else if (wr_tcon)                  tcon <= Write_data[2:0];
    else if (wrap && tcon[TCON_IE])    tcon[TCON_IF] <= 1'b1;
  end

  assign irq  = tcon[TCON_IE] & tcon[TCON_IF];
  assign leds = led;

  always_comb begin
    // NOTE: default first so no path through this block leaves Read_data unassigned (no latch).
    Read_data = '0;
    if (MemRead && hit) begin
      case (sel)
        OFF_TH[4:2]:      Read_data = th;
        OFF_TL[4:2]:      Read_data = tl;
        OFF_TCON[4:2]:    Read_data = 32'(tcon);
        OFF_LED[4:2]:     Read_data = 32'(led);
        OFF_DIGI[4:2]:    Read_data = 32'(digi_reg);
        OFF_SYSTICK[4:2]: Read_data = systick;
        default:          Read_data = '0;
      endcase
    end
  end

`ifdef MMIO_SCAN_EN
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [3:0]       nibble;
  logic [7:0]       seg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign nibble = digi_reg[{idx, 2'b00} +: 4];

  seg7_decoder u_seg7 (
    .nibble (nibble),
    .seg    (seg)
  );

  assign digi_raw = {~(4'b0001 << idx), seg};
`else
  if (SCAN_DIV == 0) begin : g_scan_div_unused
  end
  assign digi_raw = digi_reg;
`endif

  // Anodes are forced off for as long as reset is held, independent of the clock.
  assign digi = reset ? digi_raw : 12'hF00;

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph: stimulus pushes expected read responses, a monitor pops and compares.
module tb_mmio_periph;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        hit;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  localparam logic [31:0] A_TH   = BASE_ADDR + OFF_TH;
  localparam logic [31:0] A_TL   = BASE_ADDR + OFF_TL;
  localparam logic [31:0] A_TCON = BASE_ADDR + OFF_TCON;
  localparam logic [31:0] A_LED  = BASE_ADDR + OFF_LED;
  localparam logic [31:0] A_DIGI = BASE_ADDR + OFF_DIGI;
  localparam logic [31:0] A_SYS  = BASE_ADDR + OFF_SYSTICK;

  mmio_periph #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .hit        (hit),
    .leds       (leds),
    .digi       (digi),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digi;
    bit          chk_digi;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned tick;
  logic [7:0]  cur_leds = 8'h00;
  logic [11:0] cur_digi = 12'h000;
`ifdef MMIO_SCAN_EN
  bit          chk_digi = 1'b0;
`else
  bit          chk_digi = 1'b1;
`endif

  // Cycle reference for SYSTICK: clk edges seen since reset released.
  always @(posedge clk or negedge reset)
    if (!reset) tick <= 0;
    else        tick <= tick + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && MemRead) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got read at %h, expected no read pending", Address);
      end else begin
        e = sb.pop_front();
        check({e.name, ".rdata"}, Read_data, e.rdata);
        check({e.name, ".hit"},   32'(hit),  32'(e.hit));
        check({e.name, ".irq"},   32'(irq),  32'(e.irq));
        check({e.name, ".leds"},  32'(leds), 32'(e.leds));
        if (e.chk_digi) check({e.name, ".digi"}, 32'(digi), 32'(e.digi));
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] rdata, input logic h, input logic i);
    exp_t e;
    e.rdata    = rdata;
    e.hit      = h;
    e.irq      = i;
    e.leds     = cur_leds;
    e.digi     = cur_digi;
    e.chk_digi = chk_digi;
    e.name     = name;
    sb.push_back(e);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_rdata,
                    input logic exp_hit, input logic exp_irq);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Address = addr; Write_data = '0;
    push_exp(name, exp_rdata, exp_hit, exp_irq);
  endtask

  task automatic rd_systick(input string name, input logic [31:0] addr);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Address = addr; Write_data = '0;
    push_exp(name, tick, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b1; Address = addr; Write_data = data;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    #22 reset = 1'b1;

    rd("rst_th",   A_TH,   32'h0, 1'b1, 1'b0);
    rd("rst_tl",   A_TL,   32'h0, 1'b1, 1'b0);
    rd("rst_tcon", A_TCON, 32'h0, 1'b1, 1'b0);
    rd("rst_led",  A_LED,  32'h0, 1'b1, 1'b0);
    rd_systick("systick_a", A_SYS);

    wr(A_LED, 32'hFFFF_FFA5); cur_leds = 8'hA5;
    rd("led_rd",    A_LED,        32'h0000_00A5, 1'b1, 1'b0);
    rd("miss_hi",   32'h4000_0020, 32'h0, 1'b0, 1'b0);
    rd("miss_lo",   32'h3FFF_FFFC, 32'h0, 1'b0, 1'b0);
    rd("miss_off6", 32'h4000_0018, 32'h0, 1'b0, 1'b0);
    wr(32'h4000_0020, 32'hDEAD_BEEF);
    wr(32'h3FFF_FFEC, 32'h0000_003C);
    rd("th_after_miss",  A_TH,  32'h0, 1'b1, 1'b0);
    rd("led_after_miss", A_LED, 32'h0000_00A5, 1'b1, 1'b0);
    rd_systick("systick_lane3", A_SYS | 32'h3);
    wr(A_SYS, 32'h1234_5678);
    rd_systick("systick_ro", A_SYS);

    wr(A_DIGI, 32'h0000_073F); cur_digi = 12'h73F;
    rd("digi_rd", A_DIGI, 32'h0000_073F, 1'b1, 1'b0);
    wr(A_TCON, 32'hFFFF_FFF8);
    rd("tcon_mask", A_TCON, 32'h0, 1'b1, 1'b0);

    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd("tl_fe",   A_TL,   32'hFFFF_FFFE, 1'b1, 1'b0);
    rd("tl_ff",   A_TL,   32'hFFFF_FFFF, 1'b1, 1'b0);
    rd("tl_wrap", A_TL,   32'hFFFF_FFF0, 1'b1, 1'b1);
    rd("tcon_if", A_TCON, 32'h7,         1'b1, 1'b1);
    rd("tl_f2",   A_TL,   32'hFFFF_FFF2, 1'b1, 1'b1);
    wr(A_TCON, 32'h1);
    rd("tcon_clr", A_TCON, 32'h1,         1'b1, 1'b0);
    rd("tl_cont",  A_TL,   32'hFFFF_FFF5, 1'b1, 1'b0);

    wr(A_TCON, 32'h3);
    wr(A_TL, 32'hFFFF_FFFE);
    rd("tl_pre", A_TL, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wr(A_TL, 32'h5);
    rd("tl_wr_wins", A_TL,   32'h5, 1'b1, 1'b0);
    rd("tcon_keep",  A_TCON, 32'h3, 1'b1, 1'b0);
    rd("tl_after",   A_TL,   32'h7, 1'b1, 1'b0);

    wr(A_TCON, 32'h1);
    wr(A_TL, 32'hFFFF_FFFF);
    rd("tl_max",     A_TL,   32'hFFFF_FFFF, 1'b1, 1'b0);
    rd("tl_reload",  A_TL,   32'hFFFF_FFF0, 1'b1, 1'b0);
    rd("tcon_no_if", A_TCON, 32'h1,         1'b1, 1'b0);

    wr(A_TCON, 32'h0);
    wr(A_TL, 32'd100);
    rd("tl_hold1", A_TL, 32'd100, 1'b1, 1'b0);
    rd("tl_hold2", A_TL, 32'd100, 1'b1, 1'b0);

    wr(A_TL, 32'd1234);
    wr(A_LED, 32'h0000_00FF); cur_leds = 8'hFF;
    wr(A_TCON, 32'h7);
    rd("pre_rst_led", A_LED, 32'h0000_00FF, 1'b1, 1'b1);

    @(posedge clk); #2;
    MemWrite = 1'b0; MemRead = 1'b1; Address = A_TL;
    reset = 1'b0;
    #1;
    check("rst_async.rdata", Read_data,  32'h0);
    check("rst_async.irq",   32'(irq),   32'h0);
    check("rst_async.leds",  32'(leds),  32'h0);
    check("rst_async.digi",  32'(digi),  32'hF00);
    MemRead = 1'b0;
    #1;
    check("rst_idle.rdata", Read_data, 32'h0);
    @(negedge clk); #1;
    reset = 1'b1;
    cur_leds = 8'h00;
    cur_digi = 12'h000;

    rd("post_tl",   A_TL,   32'h0, 1'b1, 1'b0);
    rd("post_tcon", A_TCON, 32'h0, 1'b1, 1'b0);
    rd("post_th",   A_TH,   32'h0, 1'b1, 1'b0);
    rd("post_led",  A_LED,  32'h0, 1'b1, 1'b0);
    rd("post_digi", A_DIGI, 32'h0, 1'b1, 1'b0);
    rd_systick("post_systick", A_SYS);

`ifdef MMIO_SCAN_EN
    begin
      logic [11:0] pat [4];
      logic [11:0] prev;
      bit          found;
      pat[0] = 12'hE66; pat[1] = 12'hD4F; pat[2] = 12'hB5B; pat[3] = 12'h706;
      wr(A_DIGI, 32'h0000_1234);
      idle();
      found = 1'b0;
      prev  = digi;
      for (int k = 0; k < 64 && !found; k++) begin
        @(negedge clk);
        if (prev == 12'h706 && digi == 12'hE66) found = 1'b1;
        prev = digi;
      end
      check("scan_lock", 32'(found), 32'h1);
      chk_digi = 1'b1;
      for (int k = 1; k < 16; k++) begin
        cur_digi = pat[k / 4];
        rd($sformatf("scan_%0d", k), A_DIGI, 32'h0000_1234, 1'b1, 1'b0);
      end
    end
`endif

    idle();
    @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
